// File: rtl/pcie_legacyint_ctrl.sv
// PCIe legacy INTx sequencer: merges masked level sources and issues Assert/Deassert_INTx
// message requests over a req/ack handshake. Optional ack-timeout retry via PCIE_LEGACYINT_RETRY_EN.
module pcie_legacyint_ctrl #(
   parameter int NUM_SRC     = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_SRC-1:0] irq_i,
   input  logic [NUM_SRC-1:0] irq_mask_i,
   input  logic               intx_disable_i,
   output logic               msg_req_o,
   output logic               msg_assert_o,
   input  logic               msg_ack_i,
   output logic               int_status_o,
   output logic [1:0]         state_o,
   output logic               timeout_o
);

   // Handshake: msg_req_o/msg_assert_o are held stable until the cycle msg_ack_i is seen
   // high while msg_req_o is high; that edge completes the transfer. Ack without req is ignored.

   typedef enum logic [1:0] {
      ST_IDLE          = 2'b00,
      ST_SEND_ASSERT   = 2'b01,
      ST_ASSERTED      = 2'b10,
      ST_SEND_DEASSERT = 2'b11
   } state_t;

   if ((NUM_SRC < 1) || (NUM_SRC > 32) || (ACK_TIMEOUT < 2) || (ACK_TIMEOUT > 65535)) begin : g_param_err
      $error("pcie_legacyint_ctrl: parameter out of range");
   end

   state_t r_state;
   state_t w_state_nxt;
   logic   r_status_q;
   logic   r_pending_q;
   logic   r_msg_req;
   logic   r_msg_assert;
   logic   w_req_nxt;
   logic   w_assert_nxt;
   logic   w_ack_hit;
   logic   w_src_any;
   logic   w_timeout_fire;

   assign w_src_any = |(irq_i & ~irq_mask_i);
   assign w_ack_hit = r_msg_req & msg_ack_i;

   // Pending is taken from the registered status so the FSM sees a two-stage synchronised view.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_status_q  <= 1'b0;
         r_pending_q <= 1'b0;
      end else begin
         r_status_q  <= w_src_any;
         r_pending_q <= r_status_q & ~intx_disable_i;
      end
   end

`ifdef PCIE_LEGACYINT_RETRY_EN
   localparam logic [15:0] LP_CNT_LAST = 16'(ACK_TIMEOUT - 1);

   logic [15:0] r_wait_cnt;
   logic        r_timeout;

   assign w_timeout_fire = r_msg_req & ~msg_ack_i & (r_wait_cnt == LP_CNT_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wait_cnt <= 16'd0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= w_timeout_fire;
         if ((w_state_nxt != r_state) || w_timeout_fire || !r_msg_req) begin
            r_wait_cnt <= 16'd0;
         end else if (!msg_ack_i) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
         end
      end
   end

   assign timeout_o = r_timeout;
`else
   assign w_timeout_fire = 1'b0;
   assign timeout_o      = 1'b0;
`endif

   // State register with registered message outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_msg_req    <= 1'b0;
         r_msg_assert <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_msg_req    <= w_req_nxt;
         r_msg_assert <= w_assert_nxt;
      end
   end

   // Next state: an ack always wins over a simultaneous pending change.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:          if (r_pending_q)  w_state_nxt = ST_SEND_ASSERT;
         ST_SEND_ASSERT:   if (w_ack_hit)    w_state_nxt = ST_ASSERTED;
         ST_ASSERTED:      if (!r_pending_q) w_state_nxt = ST_SEND_DEASSERT;
         ST_SEND_DEASSERT: if (w_ack_hit)    w_state_nxt = ST_IDLE;
         default:                            w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode on the next state; a timeout opens a one-cycle request gap.
   always_comb begin
      w_req_nxt    = 1'b0;
      w_assert_nxt = 1'b0;
      case (w_state_nxt)
         ST_SEND_ASSERT: begin
            w_req_nxt    = ~w_timeout_fire;
            w_assert_nxt = 1'b1;
         end
         ST_SEND_DEASSERT: begin
            w_req_nxt    = ~w_timeout_fire;
            w_assert_nxt = 1'b0;
         end
         default: begin
            w_req_nxt    = 1'b0;
            w_assert_nxt = 1'b0;
         end
      endcase
   end

   assign msg_req_o    = r_msg_req;
   assign msg_assert_o = r_msg_assert;
   assign int_status_o = r_status_q;
   assign state_o      = r_state;

endmodule

// File: tb/tb_pcie_legacyint_ctrl.sv
// Directed self-checking bench for pcie_legacyint_ctrl; retry section active with PCIE_LEGACYINT_RETRY_EN.
module tb_pcie_legacyint_ctrl;

   localparam int NUM_SRC     = 4;
   localparam int ACK_TIMEOUT = 8;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [NUM_SRC-1:0] irq_i;
   logic [NUM_SRC-1:0] irq_mask_i;
   logic               intx_disable_i;
   logic               msg_req_o;
   logic               msg_assert_o;
   logic               msg_ack_i;
   logic               int_status_o;
   logic [1:0]         state_o;
   logic               timeout_o;

   int n_checks = 0;
   int n_errors = 0;

   pcie_legacyint_ctrl #(
      .NUM_SRC     (NUM_SRC),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .irq_i          (irq_i),
      .irq_mask_i     (irq_mask_i),
      .intx_disable_i (intx_disable_i),
      .msg_req_o      (msg_req_o),
      .msg_assert_o   (msg_assert_o),
      .msg_ack_i      (msg_ack_i),
      .int_status_o   (int_status_o),
      .state_o        (state_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input int st, input int req, input int asrt, input int sts);
      check({tag, "_state"}, 32'(state_o), 32'(st));
      check({tag, "_req"}, 32'(msg_req_o), 32'(req));
      if (req != 0) check({tag, "_type"}, 32'(msg_assert_o), 32'(asrt));
      check({tag, "_sts"}, 32'(int_status_o), 32'(sts));
      check({tag, "_to"}, 32'(timeout_o), 32'd0);
   endtask

   task automatic ack_once();
      msg_ack_i = 1'b1;
      tick();
      msg_ack_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; irq_i = '0; irq_mask_i = '0; intx_disable_i = 1'b0; msg_ack_i = 1'b0;
      tick(); tick();
      check_out("reset", 0, 0, 0, 0);
      rst_i = 1'b0;

      // Basic assert: status one edge after irq, request two edges later.
      irq_i = 4'b0001;
      tick(); check_out("a_e1", 0, 0, 0, 1);
      tick(); check_out("a_e2", 0, 0, 0, 1);
      tick(); check_out("a_e3", 1, 1, 1, 1);
      tick(); check_out("a_hold1", 1, 1, 1, 1);
      tick(); check_out("a_hold2", 1, 1, 1, 1);
      ack_once(); check_out("a_acked", 2, 0, 0, 1);
      ack_once(); check_out("a_stray_ack", 2, 0, 0, 1);

      // Source drops: deassert request, immediate ack back to IDLE.
      irq_i = 4'b0000;
      tick(); check_out("d_e1", 2, 0, 0, 0);
      tick(); check_out("d_e2", 2, 0, 0, 0);
      tick(); check_out("d_e3", 3, 1, 0, 0);
      ack_once(); check_out("d_acked", 0, 0, 0, 0);
      ack_once(); check_out("idle_stray_ack", 0, 0, 0, 0);

      // Masked source: nothing happens until unmasked.
      irq_mask_i = 4'b0100; irq_i = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         tick(); check_out("masked", 0, 0, 0, 0);
      end
      irq_mask_i = 4'b0000;
      tick(); check_out("um_e1", 0, 0, 0, 1);
      tick(); check_out("um_e2", 0, 0, 0, 1);
      tick(); check_out("um_e3", 1, 1, 1, 1);
      ack_once(); check_out("um_acked", 2, 0, 0, 1);

      // Interrupt Disable forces a Deassert; status bit stays set.
      intx_disable_i = 1'b1;
      tick(); check_out("dis_e1", 2, 0, 0, 1);
      tick(); check_out("dis_e2", 3, 1, 0, 1);
      ack_once(); check_out("dis_acked", 0, 0, 0, 1);
      intx_disable_i = 1'b0;
      tick(); check_out("en_e1", 0, 0, 0, 1);
      tick(); check_out("en_e2", 1, 1, 1, 1);
      ack_once(); check_out("en_acked", 2, 0, 0, 1);

      irq_i = 4'b0000;
      tick(); tick(); tick(); check_out("clr_send", 3, 1, 0, 0);
      ack_once(); check_out("clr_acked", 0, 0, 0, 0);

      // Source drops while Assert outstanding: no abort, Deassert one cycle after ack.
      irq_i = 4'b0001;
      tick(); tick(); tick(); check_out("na_send", 1, 1, 1, 1);
      irq_i = 4'b0000;
      tick(); check_out("na_w1", 1, 1, 1, 0);
      tick(); check_out("na_w2", 1, 1, 1, 0);
      ack_once(); check_out("na_acked", 2, 0, 0, 0);
      tick(); check_out("na_deassert", 3, 1, 0, 0);

      // Pending returns during Deassert: no abort, then back-to-back Assert.
      irq_i = 4'b0001;
      tick(); tick(); check_out("bb_wait", 3, 1, 0, 1);
      ack_once(); check_out("bb_idle", 0, 0, 0, 1);
      tick(); check_out("bb_assert", 1, 1, 1, 1);

      // Reset mid-handshake drops the request with no Deassert.
      rst_i = 1'b1; irq_i = 4'b0000;
      tick(); check_out("rst_mid", 0, 0, 0, 0);
      rst_i = 1'b0;
      tick(); check_out("rst_after", 0, 0, 0, 0);

`ifdef PCIE_LEGACYINT_RETRY_EN
      // Withheld ack: 8 cycles of request, one gap cycle with timeout pulse, same type again.
      irq_i = 4'b0001;
      tick(); tick(); tick(); check_out("rt_start", 1, 1, 1, 1);
      for (int i = 1; i < ACK_TIMEOUT; i++) begin
         tick(); check_out("rt_high", 1, 1, 1, 1);
      end
      tick();
      check("rt_gap_req", 32'(msg_req_o), 32'd0);
      check("rt_gap_to", 32'(timeout_o), 32'd1);
      check("rt_gap_state", 32'(state_o), 32'd1);
      tick(); check_out("rt_again", 1, 1, 1, 1);
      for (int i = 1; i < ACK_TIMEOUT; i++) tick();
      tick();
      check("rt_gap2_req", 32'(msg_req_o), 32'd0);
      check("rt_gap2_to", 32'(timeout_o), 32'd1);
      tick(); check_out("rt_again2", 1, 1, 1, 1);
      ack_once(); check_out("rt_acked", 2, 0, 0, 1);
      irq_i = 4'b0000;
      tick(); tick(); tick(); check_out("rt_deassert", 3, 1, 0, 0);
      ack_once(); check_out("rt_done", 0, 0, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
